// File: rtl/router_input_buffer.sv
// Per-port show-ahead flit FIFO feeding the output allocator.
// Optional packet gating (ROUTER_IN_PKT_GATE_EN) withholds req until a whole packet is buffered.
module router_input_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 11
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr,
  input  logic [WIDTH-1:0]             data_in,
  output logic                         full,
  output logic                         req,
  output logic [WIDTH-1:0]             data_out,
  input  logic                         ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push, pop;

  assign full     = (count_q == CW'(DEPTH));
  assign data_out = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

`ifdef ROUTER_IN_PKT_GATE_EN
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          tail_push, tail_pop;

  // Head is offered once a tail is resident, or when full so over-long packets cannot deadlock.
  assign req = (count_q != '0) && ((pkt_cnt_q != '0) || full);

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    tail_push = push && data_in[WIDTH-1];
    tail_pop  = pop && data_out[WIDTH-1];
    if (tail_push && !tail_pop) begin
      pkt_cnt_d = pkt_cnt_q + CW'(1);
    end else if (tail_pop && !tail_push) begin
      pkt_cnt_d = pkt_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end
`else
  assign req = (count_q != '0);
`endif

  // Push and pop decisions rely only on registered-state decodes.
  always_comb begin
    push       = wr && !full;
    pop        = ready && req;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (wr && full);
    if (push) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage is cleared on reset so data_out never presents X downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_router_input_buffer.sv
// Directed bench for router_input_buffer: vector table plus queue-scoreboarded corner sequences.
module tb_router_input_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WIDTH = 11;
  localparam int unsigned CW    = $clog2(DEPTH+1);
`ifdef ROUTER_IN_PKT_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic             wr;
  logic [WIDTH-1:0] data_in;
  logic             full;
  logic             req;
  logic [WIDTH-1:0] data_out;
  logic             ready;
  logic [CW-1:0]    count;
  logic             overflow;

  int n_checks = 0;
  int n_errors = 0;

  router_input_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .wr(wr), .data_in(data_in), .full(full),
    .req(req), .data_out(data_out), .ready(ready), .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             wr;
    logic [WIDTH-1:0] din;
    logic             rdy;
    logic [CW-1:0]    e_count;
    logic             e_req;
    logic             e_full;
    logic [WIDTH-1:0] e_dout;
    bit               chk_dout;
  } vec_t;

  vec_t vecs [10];

  // Behavioural reference for the multi-cycle sequences.
  logic [WIDTH-1:0] q [$];
  int               m_pkt;
  logic             m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic m_req();
    return (q.size() != 0) && (!GATE || (m_pkt != 0) || (q.size() == DEPTH));
  endfunction

  task automatic check_model(input string tag);
    chk({tag, " count"}, 32'(count), 32'(q.size()));
    chk({tag, " full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, " req"}, 32'(req), 32'(m_req()));
    chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    if (q.size() != 0) chk({tag, " data_out"}, 32'(data_out), 32'(q[0]));
  endtask

  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input string tag);
    logic do_pop, do_push;
    logic [WIDTH-1:0] popped;
    @(negedge clk);
    wr = w; data_in = d; ready = r;
    #1;
    do_pop  = r && m_req();
    do_push = w && (q.size() != DEPTH);
    if (w && q.size() == DEPTH) m_ovf = 1'b1;
    if (do_pop) begin
      popped = q.pop_front();
      if (popped[WIDTH-1]) m_pkt--;
    end
    if (do_push) begin
      q.push_back(d);
      if (d[WIDTH-1]) m_pkt++;
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    wr = 1'b0; data_in = '0; ready = 1'b0; reset_n = 1'b0;
    q.delete(); m_pkt = 0; m_ovf = 1'b0;

    vecs[0] = '{1'b1, 11'h001, 1'b0, 5'd1, !GATE, 1'b0, 11'h001, 1'b1};
    vecs[1] = '{1'b1, 11'h002, 1'b0, 5'd2, !GATE, 1'b0, 11'h001, 1'b1};
    vecs[2] = '{1'b1, 11'h403, 1'b0, 5'd3, 1'b1,  1'b0, 11'h001, 1'b1};
    vecs[3] = '{1'b0, 11'h000, 1'b1, 5'd2, 1'b1,  1'b0, 11'h002, 1'b1};
    vecs[4] = '{1'b0, 11'h000, 1'b1, 5'd1, 1'b1,  1'b0, 11'h403, 1'b1};
    vecs[5] = '{1'b0, 11'h000, 1'b1, 5'd0, 1'b0,  1'b0, 11'h000, 1'b0};
    vecs[6] = '{1'b0, 11'h000, 1'b1, 5'd0, 1'b0,  1'b0, 11'h000, 1'b0};
    vecs[7] = '{1'b1, 11'h4AA, 1'b1, 5'd1, 1'b1,  1'b0, 11'h4AA, 1'b1};
    vecs[8] = '{1'b0, 11'h000, 1'b1, 5'd0, 1'b0,  1'b0, 11'h000, 1'b0};
    vecs[9] = '{1'b0, 11'h000, 1'b1, 5'd0, 1'b0,  1'b0, 11'h000, 1'b0};

    #12;
    chk("reset count", 32'(count), 0);
    chk("reset req", 32'(req), 0);
    chk("reset full", 32'(full), 0);
    chk("reset overflow", 32'(overflow), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Three-flit packet, then ready held across empty and a single 0x4AA push.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wr = vecs[i].wr; data_in = vecs[i].din; ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d req", i), 32'(req), 32'(vecs[i].e_req));
      chk($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].e_full));
      chk($sformatf("vec%0d overflow", i), 32'(overflow), 0);
      if (vecs[i].chk_dout)
        chk($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].e_dout));
    end

    // Fill with non-tail flits, then one dropped push.
    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, WIDTH'(11'h010 + 11'(i)), 1'b0, "fill");
    chk("fill full", 32'(full), 1);
    chk("fill req escape", 32'(req), 1);
    step(1'b1, 11'h055, 1'b0, "ovf");
    chk("ovf overflow", 32'(overflow), 1);
    chk("ovf count", 32'(count), 16);

    // Drain; gated build needs a tail after the escape pop to keep offering.
    for (int i = 0; i < 40 && q.size() != 0; i++)
      step((GATE && i == 1) ? 1'b1 : 1'b0, 11'h4FF, 1'b1, "drain");
    chk("drain empty", 32'(count), 0);

    // Sustained push+pop at count=5 across pointer wrap.
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(11'h400 + 11'(i)), 1'b0, "pre5");
    for (int i = 0; i < 20; i++) step(1'b1, WIDTH'(11'h420 + 11'(i)), 1'b1, "stream");
    chk("stream count", 32'(count), 5);
    for (int i = 0; i < 20 && q.size() != 0; i++) step(1'b0, 11'h000, 1'b1, "drain2");
    chk("drain2 empty", 32'(count), 0);

    // Asynchronous reset mid-packet.
    for (int i = 0; i < 7; i++) step(1'b1, WIDTH'(11'h060 + 11'(i)), 1'b0, "pre7");
    chk("pre7 count", 32'(count), 7);
    wr = 1'b0; ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async count", 32'(count), 0);
    chk("async req", 32'(req), 0);
    chk("async full", 32'(full), 0);
    chk("async overflow", 32'(overflow), 0);
    q.delete(); m_pkt = 0; m_ovf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 11'h4AB, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual running, required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/router_input_buffer.md
# router_input_buffer

Per-port flit FIFO that sits directly upstream of the router output allocator. It accepts 11-bit flits (bit 10 = tail) from the link or deserializer and presents the head flit to the allocator. Its `req`/`data_out` outputs drive the allocator's `req_N`/`data_in_N` inputs, and the allocator's `ready_N` output drives its `ready` input. Optional packet gating holds back `req` until a whole packet is buffered, so the allocator's locked `msg_N` state never starves mid-packet.

## Interface
- `DEPTH`, 16: flit entries. Must be a power of 2, ≥ 2.
- `WIDTH`, 11: flit width. Bit `WIDTH-1` is the tail flag.
- `clk`  in  1: sole clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `wr`  in  1: push request from upstream.
- `data_in`  in  WIDTH: flit to push.
- `full`  out  1: `count == DEPTH`.
- `req`  out  1: head flit valid and eligible (see Operation).
- `data_out`  out  WIDTH: head flit, show-ahead (`mem[rd_ptr]`).
- `ready`  in  1: pop strobe from allocator. May be high while `req` is low.
- `count`  out  $clog2(DEPTH+1): occupancy.
- `overflow`  out  1: sticky; a push was dropped.

## Operation
- Push accepted iff `wr && !full`. Accepted flit is written to `mem[wr_ptr]`, then `wr_ptr` increments.
- Pop occurs iff `ready && req`. `rd_ptr` increments.
  - `ready` without `req` is ignored. The allocator drives `ready=~out_FIFO_full` regardless of request.
- Pointers are log2(DEPTH) bits and wrap naturally at DEPTH.
- `count` update:
  - +1 on accepted push only.
  - −1 on pop only.
  - Unchanged on simultaneous push+pop.
- Full:
  - `wr` while `full` drops the flit and sets `overflow`.
  - Push is refused even if a pop happens in the same cycle; `full` is a registered-state decode.
- Empty: `req=0`. `data_out` is don't-care but must not glitch X into the allocator; it holds `mem[rd_ptr]`.
- `pkt_cnt` (internal, $clog2(DEPTH+1) bits) counts tail flits resident in the buffer:
  - +1 on accepted push with tail.
  - −1 on pop with tail.
  - Unchanged when both occur.
- `overflow` clears only on reset.
- Reset mid-operation discards all content immediately. A packet partially delivered to the allocator is truncated; recovery is the allocator's and upstream's responsibility.

## Timing
- Reset values: `req=0`, `full=0`, `count=0`, `overflow=0`, pointers 0, `pkt_cnt=0`. `data_out` is undefined after reset.
- Write-to-read latency: a flit pushed at edge N is visible on `data_out` and can raise `req` after edge N (usable in cycle N+1).
- Pop is combinational on the allocator side: `data_out` is consumed in the same cycle `ready && req` is high. The next flit appears after that edge.
- Back-to-back: one push and one pop per cycle, sustained; no bubbles when non-empty.
- `full`, `count`, `req` are decodes of registered state. No combinational path from `wr` or `ready` to any output.

## Configuration
- `ROUTER_IN_PKT_GATE_EN` defined:
  - `req = (count != 0) && ((pkt_cnt != 0) || full)`.
  - The head is offered only once at least one complete packet (tail included) is buffered.
  - The `full` escape prevents deadlock for packets longer than DEPTH; those revert to cut-through.
- Not defined:
  - `req = (count != 0)` (cut-through).
  - `pkt_cnt` logic is not instantiated.

## Test plan
- Reset, then push 3 flits `0x001, 0x002, 0x403` with `ready=0`:
  - `count=3`, `data_out=0x001`.
  - With gate enabled, `req` rises only in the cycle after `0x403` is accepted.
  - Without gate, `req` rises the cycle after `0x001` is accepted.
- Fill DEPTH=16 entries, then push `0x055` with `ready=0`: `full=1`, `overflow=1`, `count` stays 16, and `0x055` is never output.
- Simultaneous push and pop at `count=5` for 20 cycles: `count` stays 5, output order matches input order across pointer wrap.
- Gate enabled: push 16 non-tail flits: `full=1`, `req=1` via escape, and `ready` drains them in order.
- `ready=1` held while empty, then a single push of `0x4AA`: exactly one pop occurs, and `count` returns to 0 one cycle after `req` rises.
- Assert `reset_n=0` mid-packet with `count=7`: all outputs return to reset values asynchronously, before the next clock edge.
